// File: rtl/serial_slave_port_if.sv
// Lane bundle between address_decoder and one serial slave endpoint.
// Handshake: the decoder starts a request frame (rx start bit 0) only while ready=1;
// a response frame begins with tx start bit 0, and split=1 marks a deferred request.
interface serial_slave_port_if;
  logic       rx;
  logic       tx;
  logic       busy;
  logic       ready;
  logic       split;
  logic [3:0] dbg_state;

  modport slave  (input rx, busy, output tx, ready, split, dbg_state);
  modport master (output rx, busy, input tx, ready, split, dbg_state);
endinterface

// File: rtl/serial_slave_port.sv
// Bit-serial slave endpoint: deserialises read/write requests, accesses a local
// word array and serialises a response; busy defers completion as a split transaction.
module serial_slave_port #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2048
) (
  input  logic                 clk,
  input  logic                 rstn,
  serial_slave_port_if.slave   bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    RX_RW      = 4'd1,
    RX_ADDR    = 4'd2,
    RX_DATA    = 4'd3,
    TURN       = 4'd4,
    TX_START   = 4'd5,
    TX_STAT    = 4'd6,
    TX_DATA    = 4'd7,
    SPLIT_WAIT = 4'd8
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                status_q, status_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [IDX_W-1:0]    idx;
  logic                access;
  logic                unused_addr;

  // Upper address bits only exist so the frame length is right; they alias.
  assign idx         = addr_q[IDX_W-1:0];
  assign unused_addr = ^addr_q;
  assign access      = ((state_q == TURN) || (state_q == SPLIT_WAIT)) && !bus.busy;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    case (state_q)
      IDLE: if (!bus.rx) state_d = RX_RW;
      RX_RW: begin
        rw_d    = bus.rx;
        cnt_d   = '0;
        state_d = RX_ADDR;
      end
      RX_ADDR: begin
        addr_d = {bus.rx, addr_q[ADDR_W-1:1]};
        if (cnt_q == CNT_W'(ADDR_W - 1)) begin
          cnt_d   = '0;
          state_d = rw_q ? RX_DATA : TURN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        data_d = {bus.rx, data_q[DATA_W-1:1]};
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d   = '0;
          state_d = TURN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TURN, SPLIT_WAIT: begin
        // A held request stays in SPLIT_WAIT until busy drops; TURN always answers.
        if (access) begin
          status_d = 1'b1;
          if (!rw_q) rdata_d = mem[idx];
          state_d = TX_START;
        end else if (state_q == TURN) begin
          status_d = 1'b0;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        cnt_d   = '0;
        state_d = TX_STAT;
      end
      TX_STAT: begin
        if (!status_q)  state_d = SPLIT_WAIT;
        else if (rw_q)  state_d = IDLE;
        else            state_d = TX_DATA;
      end
      TX_DATA: begin
        rdata_d = rdata_q >> 1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      status_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
    end
  end

  always_ff @(posedge clk) begin
    if (access && rw_q) mem[idx] <= data_q;
  end

  always_comb begin
    case (state_q)
      TX_START: bus.tx = 1'b0;
      TX_STAT:  bus.tx = status_q;
      TX_DATA:  bus.tx = rdata_q[0];
      default:  bus.tx = 1'b1;
    endcase
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.split     = (state_q == SPLIT_WAIT);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_serial_slave_port.sv
// Directed bench for serial_slave_port: drivers issue request frames, a monitor
// compares every response frame bit against the expected queue.
module tb_serial_slave_port;

  logic clk;
  logic rstn;
  serial_slave_port_if bus ();

  serial_slave_port #(.ADDR_W(12), .DATA_W(8), .DEPTH(2048)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [0:0] exp_q  [$];
  int         len_q  [$];
  logic [1:0] post_q [$];
  int         remaining = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard feed ----------------
  task automatic push_frame(input logic status, input logic has_data, input logic [7:0] data,
                            input logic post_ready, input logic post_split);
    int len;
    exp_q.push_back(1'b0);
    exp_q.push_back(status);
    len = 2;
    if (has_data) begin
      for (int i = 0; i < 8; i++) exp_q.push_back(data[i]);
      len += 8;
    end
    len_q.push_back(len);
    post_q.push_back({post_ready, post_split});
  endtask

  // ---------------- drivers ----------------
  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.rx = b;
  endtask

  task automatic send_req(input logic rw, input logic [11:0] addr, input logic [7:0] data);
    send_bit(1'b0);
    send_bit(rw);
    for (int i = 0; i < 12; i++) send_bit(addr[i]);
    if (rw) for (int i = 0; i < 8; i++) send_bit(data[i]);
    @(negedge clk);
    bus.rx = 1'b1;
    check("turn_tx", 32'(bus.tx), 32'd1);
    @(negedge clk);
    check("start_latency", 32'(bus.tx), 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(bus.ready), 32'd1);
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [7:0] data);
    push_frame(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    send_req(1'b1, addr, data);
    wait_idle();
  endtask

  task automatic do_read(input logic [11:0] addr, input logic [7:0] exp_data);
    push_frame(1'b1, 1'b1, exp_data, 1'b1, 1'b0);
    send_req(1'b0, addr, 8'h00);
    wait_idle();
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [0:0] exp_bit;
    logic [1:0] post_exp;
    logic       post_pending;
    post_pending = 1'b0;
    post_exp     = 2'b00;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1) begin
        if (post_pending) begin
          check("post_frame_ready_split", 32'({bus.ready, bus.split}), 32'(post_exp));
          post_pending = 1'b0;
        end
        if (remaining == 0 && bus.tx === 1'b0) begin
          if (len_q.size() == 0) begin
            check("unexpected_frame", 32'(bus.tx), 32'd1);
          end else begin
            remaining = len_q.pop_front();
            post_exp  = post_q.pop_front();
          end
        end
        if (remaining > 0) begin
          exp_bit = exp_q.pop_front();
          check("tx_bit", 32'(bus.tx), 32'(exp_bit));
          remaining--;
          if (remaining == 0) post_pending = 1'b1;
        end
      end else begin
        remaining    = 0;
        post_pending = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int n;
    rstn     = 1'b0;
    bus.rx   = 1'b1;
    bus.busy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(bus.tx), 32'd1);
    check("reset_ready", 32'(bus.ready), 32'd1);
    check("reset_split", 32'(bus.split), 32'd0);
    check("reset_state", 32'(bus.dbg_state), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Plain write then read
    do_write(12'h012, 8'hA5);
    do_read(12'h012, 8'hA5);

    // Split read: status 0 then resume frame carrying the data
    bus.busy = 1'b1;
    push_frame(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    send_req(1'b0, 12'h012, 8'h00);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("split_hold", 32'({bus.split, bus.tx, bus.ready}), 32'b110);
    end
    push_frame(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0);
    bus.busy = 1'b0;
    @(negedge clk);
    check("split_fall", 32'({bus.split, bus.tx}), 32'b00);
    wait_idle();

    // Split write: array untouched until release
    do_write(12'h020, 8'h11);
    bus.busy = 1'b1;
    push_frame(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    send_req(1'b1, 12'h020, 8'h3C);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("split_write_held", 32'(dut.mem[32]), 32'h11);
    end
    push_frame(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    bus.busy = 1'b0;
    @(negedge clk);
    check("split_write_fall", 32'(bus.split), 32'd0);
    wait_idle();
    check("split_write_commit", 32'(dut.mem[32]), 32'h3C);
    do_read(12'h020, 8'h3C);

    // Alias: bit 11 is ignored with 2048 words
    do_write(12'h812, 8'h77);
    do_read(12'h012, 8'h77);

    // Reset mid-frame after 5 address bits
    send_bit(1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'(12'h012 >> i));
    @(negedge clk);
    bus.rx = 1'b1;
    rstn   = 1'b0;
    #1;
    check("midreset_tx", 32'(bus.tx), 32'd1);
    check("midreset_ready", 32'(bus.ready), 32'd1);
    check("midreset_split", 32'(bus.split), 32'd0);
    check("midreset_state", 32'(bus.dbg_state), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    do_read(12'h012, 8'h77);

    // rx held low during response data bits must not start a frame
    push_frame(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
    send_req(1'b0, 12'h012, 8'h00);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.rx = 1'b0;
    end
    @(negedge clk);
    bus.rx = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("ignored_rx_idle", 32'(bus.ready), 32'd1);
      @(negedge clk);
    end
    do_write(12'h100, 8'h5A);
    do_read(12'h100, 8'h5A);
    do_read(12'h012, 8'h77);

    // Drain scoreboard with a bound
    n = 0;
    while ((exp_q.size() != 0 || remaining != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
